// File: rtl/lc3_io_pkg.sv
// Shared definitions for the LC-3 memory/IO access controller: register map,
// FSM states and status-register bit positions.
package lc3_io_pkg;

    localparam logic [15:0] KBSR_ADDR_DEF = 16'hFE00;
    localparam logic [15:0] KBDR_ADDR_DEF = 16'hFE02;
    localparam logic [15:0] DSR_ADDR_DEF  = 16'hFE04;
    localparam logic [15:0] DDR_ADDR_DEF  = 16'hFE06;

    localparam int READY_BIT = 15;
    localparam int IE_BIT    = 14;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    // Order matches the decode index of the register address table.
    typedef enum logic [1:0] {SEL_KBSR, SEL_KBDR, SEL_DSR, SEL_DDR} reg_sel_t;

endpackage

// File: rtl/mem_io_ctrl_mmio_regs.sv
// Memory-mapped keyboard/display registers, their handshakes and the read mux.
// Only status bits and the low data byte are stored; the rest reads as zero.
module mmio_regs
    import lc3_io_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  reg_sel_t   wr_sel,
    input  logic [15:0] wr_data,
    input  logic       rd_en,
    input  reg_sel_t   rd_sel,
    output logic [15:0] rd_val,
    input  logic       kb_valid,
    input  logic [7:0] kb_data,
    output logic       kb_ready,
    output logic       kb_int,
    output logic       disp_valid,
    output logic [7:0] disp_data,
    input  logic       disp_ready
);

    logic       kb_full_reg;
    logic       kb_ie_reg;
    logic [7:0] kbdr_reg;
    logic       disp_rdy_reg;
    logic [7:0] ddr_reg;
    logic       kb_take;
    logic       disp_take;
    logic       unused_wr_bits;

    assign kb_take        = kb_valid & ~kb_full_reg;
    assign disp_take      = disp_ready & ~disp_rdy_reg;
    assign unused_wr_bits = &{1'b0, wr_data[15], wr_data[13:8]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            kb_full_reg  <= 1'b0;
            kb_ie_reg    <= 1'b0;
            kbdr_reg     <= 8'h00;
            disp_rdy_reg <= 1'b1;
            ddr_reg      <= 8'h00;
        end else begin
            // A KBDR read only happens with a character present, so it never
            // collides with a new character being taken.
            if (kb_take) begin
                kbdr_reg    <= kb_data;
                kb_full_reg <= 1'b1;
            end else if (rd_en && rd_sel == SEL_KBDR) begin
                kb_full_reg <= 1'b0;
            end
            if (wr_en && wr_sel == SEL_KBSR) begin
                kb_ie_reg <= wr_data[IE_BIT];
            end
            // A DDR write while the previous character is unsent is dropped.
            if (disp_take) begin
                disp_rdy_reg <= 1'b1;
            end else if (wr_en && wr_sel == SEL_DDR && disp_rdy_reg) begin
                ddr_reg      <= wr_data[7:0];
                disp_rdy_reg <= 1'b0;
            end
        end
    end

    always_comb begin
        rd_val = 16'h0000;
        case (rd_sel)
            SEL_KBSR: begin
                rd_val[READY_BIT] = kb_full_reg;
                rd_val[IE_BIT]    = kb_ie_reg;
            end
            SEL_KBDR: rd_val = {8'h00, kbdr_reg};
            SEL_DSR:  rd_val[READY_BIT] = disp_rdy_reg;
            default:  rd_val = 16'h0000;
        endcase
    end

    assign kb_ready   = ~kb_full_reg;
    assign kb_int     = kb_full_reg & kb_ie_reg;
    assign disp_valid = ~disp_rdy_reg;
    assign disp_data  = ddr_reg;

endmodule

// File: rtl/mem_io_ctrl.sv
// Memory/IO access controller: decodes MAR, runs a multi-cycle RAM access or a
// single-cycle register access, and pulses ready for one cycle when done.
module mem_io_ctrl
    import lc3_io_pkg::*;
#(
    parameter int          MEM_LATENCY = 1,
    parameter logic [15:0] KBSR_ADDR   = KBSR_ADDR_DEF,
    parameter logic [15:0] KBDR_ADDR   = KBDR_ADDR_DEF,
    parameter logic [15:0] DSR_ADDR    = DSR_ADDR_DEF,
    parameter logic [15:0] DDR_ADDR    = DDR_ADDR_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mio_en,
    input  logic        r_w,
    input  logic [15:0] mar,
    input  logic [15:0] mdr,
    output logic [15:0] rd_data,
    output logic        ready,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_data,
    output logic        mem_wren,
    input  logic [15:0] mem_q,
    input  logic        kb_valid,
    input  logic [7:0]  kb_data,
    output logic        kb_ready,
    output logic        kb_int,
    output logic        disp_valid,
    output logic [7:0]  disp_data,
    input  logic        disp_ready
);

    localparam int CNT_W = $clog2(MEM_LATENCY + 2);
    localparam logic [3:0][15:0] REG_ADDRS = {DDR_ADDR, DSR_ADDR, KBDR_ADDR, KBSR_ADDR};

    state_t           state_reg;
    logic [15:0]      addr_reg;
    logic [15:0]      data_reg;
    logic             we_reg;
    logic             io_reg;
    reg_sel_t         sel_reg;
    logic [CNT_W-1:0] cnt_reg;

    logic [3:0]  hit;
    logic        is_io;
    reg_sel_t    hit_sel;
    logic        io_last;
    logic [15:0] reg_rd_val;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_decode
            assign hit[gi] = (mar == REG_ADDRS[gi]);
        end
    endgenerate

    assign is_io = |hit;

    always_comb begin
        hit_sel = SEL_KBSR;
        for (int i = 0; i < 4; i++) begin
            if (hit[i]) hit_sel = reg_sel_t'(i[1:0]);
        end
    end

    // Register side effects fire on the single ACCESS cycle of an IO access.
    assign io_last = (state_reg == ACCESS) && (cnt_reg == '0) && io_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            addr_reg  <= 16'h0000;
            data_reg  <= 16'h0000;
            we_reg    <= 1'b0;
            io_reg    <= 1'b0;
            sel_reg   <= SEL_KBSR;
            cnt_reg   <= '0;
            mem_wren  <= 1'b0;
            rd_data   <= 16'h0000;
            ready     <= 1'b0;
        end else begin
            mem_wren <= 1'b0;
            ready    <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (mio_en) begin
                        addr_reg  <= mar;
                        data_reg  <= mdr;
                        we_reg    <= r_w;
                        io_reg    <= is_io;
                        sel_reg   <= hit_sel;
                        cnt_reg   <= is_io ? '0 : CNT_W'(MEM_LATENCY);
                        mem_wren  <= r_w & ~is_io;
                        state_reg <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (cnt_reg == '0) begin
                        if (!we_reg) rd_data <= io_reg ? reg_rd_val : mem_q;
                        ready     <= 1'b1;
                        state_reg <= DONE;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                DONE:    state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign mem_addr = addr_reg;
    assign mem_data = data_reg;

    mmio_regs u_regs (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (io_last & we_reg),
        .wr_sel     (sel_reg),
        .wr_data    (data_reg),
        .rd_en      (io_last & ~we_reg),
        .rd_sel     (sel_reg),
        .rd_val     (reg_rd_val),
        .kb_valid   (kb_valid),
        .kb_data    (kb_data),
        .kb_ready   (kb_ready),
        .kb_int     (kb_int),
        .disp_valid (disp_valid),
        .disp_data  (disp_data),
        .disp_ready (disp_ready)
    );

endmodule

// File: tb/tb_mem_io_ctrl.sv
// Bench for mem_io_ctrl: two instances (RAM latency 1 and 3) driven in lockstep
// and compared against a register/memory reference model.
module tb_mem_io_ctrl;

    localparam logic [15:0] A_KBSR = 16'hFE00;
    localparam logic [15:0] A_KBDR = 16'hFE02;
    localparam logic [15:0] A_DSR  = 16'hFE04;
    localparam logic [15:0] A_DDR  = 16'hFE06;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        mio_en0, mio_en1, r_w;
    logic [15:0] mar, mdr;
    logic        kb_valid, disp_ready;
    logic [7:0]  kb_data;

    logic [15:0] rd_data0, rd_data1, mem_addr0, mem_addr1, mem_data0, mem_data1;
    logic [15:0] mem_q0, mem_q1;
    logic        ready0, ready1, mem_wren0, mem_wren1;
    logic        kb_ready0, kb_ready1, kb_int0, kb_int1, disp_valid0, disp_valid1;
    logic [7:0]  disp_data0, disp_data1;

    mem_io_ctrl #(.MEM_LATENCY(1)) dut1 (
        .clk(clk), .reset(reset), .mio_en(mio_en0), .r_w(r_w), .mar(mar), .mdr(mdr),
        .rd_data(rd_data0), .ready(ready0), .mem_addr(mem_addr0), .mem_data(mem_data0),
        .mem_wren(mem_wren0), .mem_q(mem_q0), .kb_valid(kb_valid), .kb_data(kb_data),
        .kb_ready(kb_ready0), .kb_int(kb_int0), .disp_valid(disp_valid0),
        .disp_data(disp_data0), .disp_ready(disp_ready)
    );

    mem_io_ctrl #(.MEM_LATENCY(3)) dut3 (
        .clk(clk), .reset(reset), .mio_en(mio_en1), .r_w(r_w), .mar(mar), .mdr(mdr),
        .rd_data(rd_data1), .ready(ready1), .mem_addr(mem_addr1), .mem_data(mem_data1),
        .mem_wren(mem_wren1), .mem_q(mem_q1), .kb_valid(kb_valid), .kb_data(kb_data),
        .kb_ready(kb_ready1), .kb_int(kb_int1), .disp_valid(disp_valid1),
        .disp_data(disp_data1), .disp_ready(disp_ready)
    );

    // RAMs with read latency 1 and 3 (address to q valid)
    logic [15:0] ram0 [65536];
    logic [15:0] ram1 [65536];
    logic [15:0] pipe1a, pipe1b;
    always @(posedge clk) begin
        if (mem_wren0) ram0[mem_addr0] <= mem_data0;
        mem_q0 <= ram0[mem_addr0];
    end
    always @(posedge clk) begin
        if (mem_wren1) ram1[mem_addr1] <= mem_data1;
        pipe1a <= ram1[mem_addr1];
        pipe1b <= pipe1a;
        mem_q1 <= pipe1b;
    end

    logic        rdy_v [2], wren_v [2], kbr_v [2], kbi_v [2], dv_v [2];
    logic [15:0] rdd_v [2], madr_v [2], mdat_v [2];
    logic [7:0]  dd_v [2];
    assign rdy_v[0] = ready0;       assign rdy_v[1] = ready1;
    assign wren_v[0] = mem_wren0;   assign wren_v[1] = mem_wren1;
    assign kbr_v[0] = kb_ready0;    assign kbr_v[1] = kb_ready1;
    assign kbi_v[0] = kb_int0;      assign kbi_v[1] = kb_int1;
    assign dv_v[0] = disp_valid0;   assign dv_v[1] = disp_valid1;
    assign dd_v[0] = disp_data0;    assign dd_v[1] = disp_data1;
    assign rdd_v[0] = rd_data0;     assign rdd_v[1] = rd_data1;
    assign madr_v[0] = mem_addr0;   assign madr_v[1] = mem_addr1;
    assign mdat_v[0] = mem_data0;   assign mdat_v[1] = mem_data1;

    int n_cmp = 0;
    int n_err = 0;

    // Results of the last access, per instance
    logic [15:0] res_q [2];
    int          res_lat [2], res_rdy [2], res_wren [2];

    // Reference model
    logic        ref_full, ref_ie, ref_drdy;
    logic [7:0]  ref_char, ref_ddr;
    logic [15:0] ref_mem [logic [15:0]];
    logic [15:0] last_rd;

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic bit is_reg(input logic [15:0] a);
        return a inside {A_KBSR, A_KBDR, A_DSR, A_DDR};
    endfunction

    function automatic int exp_lat(input int i, input logic [15:0] a);
        return is_reg(a) ? 2 : lat_of(i) + 2;
    endfunction

    task automatic model_reset();
        ref_full = 1'b0; ref_ie = 1'b0; ref_drdy = 1'b1;
        ref_char = 8'h00; ref_ddr = 8'h00; last_rd = 16'h0000;
    endtask

    task automatic model_access(input logic w, input logic [15:0] a, input logic [15:0] d,
                                output logic [15:0] exp_q);
        if (!w) begin
            case (a)
                A_KBSR: exp_q = {ref_full, ref_ie, 14'h0};
                A_KBDR: begin exp_q = {8'h00, ref_char}; ref_full = 1'b0; end
                A_DSR:  exp_q = {ref_drdy, 15'h0};
                A_DDR:  exp_q = 16'h0000;
                default: exp_q = ref_mem.exists(a) ? ref_mem[a] : 16'h0000;
            endcase
            last_rd = exp_q;
        end else begin
            exp_q = last_rd;
            case (a)
                A_KBSR: ref_ie = d[14];
                A_DDR: if (ref_drdy) begin ref_ddr = d[7:0]; ref_drdy = 1'b0; end
                A_KBDR, A_DSR: ;
                default: ref_mem[a] = d;
            endcase
        end
    endtask

    // One access on both instances; observes a fixed 9-cycle window after edge 0.
    task automatic access(input logic w, input logic [15:0] a, input logic [15:0] d);
        @(posedge clk); #1;
        mio_en0 = 1'b1; mio_en1 = 1'b1; r_w = w; mar = a; mdr = d;
        @(posedge clk); #1;
        mio_en0 = 1'b0; mio_en1 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            res_lat[i] = -1; res_rdy[i] = 0; res_wren[i] = 0;
        end
        for (int c = 1; c <= 9; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (rdy_v[i]) begin
                    res_rdy[i]++;
                    if (res_lat[i] < 0) begin res_lat[i] = c; res_q[i] = rdd_v[i]; end
                end
                if (wren_v[i]) res_wren[i]++;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic kb_send(input logic [7:0] ch);
        @(posedge clk); #1;
        kb_valid = 1'b1; kb_data = ch;
        @(posedge clk); #1;
        kb_valid = 1'b0;
        if (!ref_full) begin ref_full = 1'b1; ref_char = ch; end
    endtask

    task automatic disp_pulse();
        @(posedge clk); #1;
        disp_ready = 1'b1;
        @(posedge clk); #1;
        disp_ready = 1'b0;
        ref_drdy = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0; mio_en0 = 1'b0; mio_en1 = 1'b0; r_w = 1'b0; mar = 16'h0; mdr = 16'h0;
        kb_valid = 1'b0; kb_data = 8'h0; disp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if ({rdy_v[i], wren_v[i], kbr_v[i], kbi_v[i], dv_v[i], rdd_v[i], madr_v[i], mdat_v[i]}
                !== {5'b00100, 48'h0}) begin
                n_err++;
                $display("FAIL reset_state dut%0d: got rdy=%b wren=%b kbr=%b kbi=%b dv=%b rd=%h addr=%h data=%h, want kbr=1 rest 0",
                         i, rdy_v[i], wren_v[i], kbr_v[i], kbi_v[i], dv_v[i], rdd_v[i], madr_v[i], mdat_v[i]);
            end
        end
        reset = 1'b1;
        model_reset();
        @(posedge clk); #1;
    endtask

    task automatic test_ram();
        logic [15:0] exp;
        model_access(1'b1, 16'h3000, 16'hBEEF, exp);
        access(1'b1, 16'h3000, 16'hBEEF);
        for (int i = 0; i < 2; i++) begin
            $display("ram write dut%0d: wren_cycles=%0d ready_cycle=%0d", i, res_wren[i], res_lat[i]);
            n_cmp++;
            if (res_wren[i] !== 1) begin n_err++; $display("FAIL ram_wren_cycles dut%0d: got %0d want 1", i, res_wren[i]); end
            n_cmp++;
            if (res_lat[i] !== exp_lat(i, 16'h3000)) begin n_err++; $display("FAIL ram_wr_latency dut%0d: got %0d want %0d", i, res_lat[i], exp_lat(i, 16'h3000)); end
        end
        model_access(1'b0, 16'h3000, 16'h0, exp);
        access(1'b0, 16'h3000, 16'h0);
        for (int i = 0; i < 2; i++) begin
            $display("ram read dut%0d: rd_data=%h ready_cycle=%0d", i, res_q[i], res_lat[i]);
            n_cmp++;
            if (res_q[i] !== exp) begin n_err++; $display("FAIL ram_rd_data dut%0d: got %h want %h", i, res_q[i], exp); end
            n_cmp++;
            if (res_lat[i] !== exp_lat(i, 16'h3000) || res_rdy[i] !== 1) begin
                n_err++; $display("FAIL ram_rd_ready dut%0d: got cycle %0d width %0d want cycle %0d width 1", i, res_lat[i], res_rdy[i], exp_lat(i, 16'h3000));
            end
        end
    endtask

    task automatic test_keyboard();
        logic [15:0] exp;
        logic [15:0] seq_a [3];
        seq_a[0] = A_KBSR; seq_a[1] = A_KBDR; seq_a[2] = A_KBSR;
        kb_send(8'h41);
        for (int k = 0; k < 3; k++) begin
            model_access(1'b0, seq_a[k], 16'h0, exp);
            access(1'b0, seq_a[k], 16'h0);
            for (int i = 0; i < 2; i++) begin
                $display("kb read %h dut%0d: rd_data=%h", seq_a[k], i, res_q[i]);
                n_cmp++;
                if (res_q[i] !== exp || res_lat[i] !== 2) begin
                    n_err++; $display("FAIL kb_read_%0d dut%0d: got %h at %0d want %h at 2", k, i, res_q[i], res_lat[i], exp);
                end
            end
        end
        // Second character held across a KBDR read is taken the cycle after the clear.
        kb_send(8'h43);
        @(posedge clk); #1;
        kb_valid = 1'b1; kb_data = 8'h42;
        @(posedge clk); #1;
        mio_en0 = 1'b1; mio_en1 = 1'b1; r_w = 1'b0; mar = A_KBDR;
        @(posedge clk); #1;
        mio_en0 = 1'b0; mio_en1 = 1'b0;
        model_access(1'b0, A_KBDR, 16'h0, exp);
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (kbr_v[i] !== 1'b0) begin n_err++; $display("FAIL kb_ready_in_access dut%0d: got %b want 0", i, kbr_v[i]); end
        end
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) begin
            $display("kb held-char dut%0d: ready=%b rd_data=%h kb_ready=%b", i, rdy_v[i], rdd_v[i], kbr_v[i]);
            n_cmp++;
            if ({rdy_v[i], kbr_v[i], rdd_v[i]} !== {2'b11, exp}) begin
                n_err++; $display("FAIL kb_done_cycle dut%0d: got ready=%b kb_ready=%b rd=%h want 1 1 %h", i, rdy_v[i], kbr_v[i], rdd_v[i], exp);
            end
        end
        @(posedge clk); #1;
        kb_valid = 1'b0;
        ref_full = 1'b1; ref_char = 8'h42;
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (kbr_v[i] !== 1'b0) begin n_err++; $display("FAIL kb_second_taken dut%0d: kb_ready got %b want 0", i, kbr_v[i]); end
        end
        model_access(1'b0, A_KBDR, 16'h0, exp);
        access(1'b0, A_KBDR, 16'h0);
        for (int i = 0; i < 2; i++) begin
            $display("kb second char dut%0d: rd_data=%h", i, res_q[i]);
            n_cmp++;
            if (res_q[i] !== exp) begin n_err++; $display("FAIL kb_second_char dut%0d: got %h want %h", i, res_q[i], exp); end
        end
    endtask

    task automatic test_interrupt();
        logic [15:0] exp;
        model_access(1'b1, A_KBSR, 16'h4000, exp);
        access(1'b1, A_KBSR, 16'h4000);
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (kbi_v[i] !== (ref_full & ref_ie)) begin n_err++; $display("FAIL int_after_ie dut%0d: got %b want %b", i, kbi_v[i], ref_full & ref_ie); end
        end
        kb_send(8'h55);
        for (int i = 0; i < 2; i++) begin
            $display("interrupt dut%0d: kb_int=%b after char", i, kbi_v[i]);
            n_cmp++;
            if (kbi_v[i] !== (ref_full & ref_ie)) begin n_err++; $display("FAIL int_after_char dut%0d: got %b want %b", i, kbi_v[i], ref_full & ref_ie); end
        end
        model_access(1'b0, A_KBSR, 16'h0, exp);
        access(1'b0, A_KBSR, 16'h0);
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (res_q[i] !== exp) begin n_err++; $display("FAIL int_kbsr_read dut%0d: got %h want %h", i, res_q[i], exp); end
        end
        model_access(1'b0, A_KBDR, 16'h0, exp);
        access(1'b0, A_KBDR, 16'h0);
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (kbi_v[i] !== (ref_full & ref_ie) || res_q[i] !== exp) begin
                n_err++; $display("FAIL int_after_read dut%0d: got int=%b rd=%h want int=%b rd=%h", i, kbi_v[i], res_q[i], ref_full & ref_ie, exp);
            end
        end
    endtask

    task automatic test_display();
        logic [15:0] exp;
        logic [15:0] wr_vals [2];
        wr_vals[0] = 16'h0058; wr_vals[1] = 16'h0077;
        for (int k = 0; k < 2; k++) begin
            model_access(1'b1, A_DDR, wr_vals[k], exp);
            access(1'b1, A_DDR, wr_vals[k]);
            for (int i = 0; i < 2; i++) begin
                $display("display write %h dut%0d: disp_valid=%b disp_data=%h ready_width=%0d", wr_vals[k], i, dv_v[i], dd_v[i], res_rdy[i]);
                n_cmp++;
                if ({dv_v[i], dd_v[i]} !== {~ref_drdy, ref_ddr} || res_rdy[i] !== 1) begin
                    n_err++; $display("FAIL disp_write_%0d dut%0d: got valid=%b data=%h rdy=%0d want %b %h 1", k, i, dv_v[i], dd_v[i], res_rdy[i], ~ref_drdy, ref_ddr);
                end
            end
        end
        disp_pulse();
        model_access(1'b0, A_DSR, 16'h0, exp);
        access(1'b0, A_DSR, 16'h0);
        for (int i = 0; i < 2; i++) begin
            $display("display dsr dut%0d: rd_data=%h disp_valid=%b", i, res_q[i], dv_v[i]);
            n_cmp++;
            if (res_q[i] !== exp || dv_v[i] !== 1'b0) begin
                n_err++; $display("FAIL disp_dsr_read dut%0d: got %h valid=%b want %h valid=0", i, res_q[i], dv_v[i], exp);
            end
        end
    endtask

    task automatic test_reset_mid_access();
        logic [15:0] exp;
        int          pulses [2];
        @(posedge clk); #1;
        mio_en0 = 1'b1; mio_en1 = 1'b1; r_w = 1'b1; mar = 16'h2222; mdr = 16'hA5A5;
        @(posedge clk); #1;
        mio_en0 = 1'b0; mio_en1 = 1'b0;
        reset = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            $display("mid-access reset dut%0d: ready=%b wren=%b addr=%h", i, rdy_v[i], wren_v[i], madr_v[i]);
            n_cmp++;
            if ({rdy_v[i], wren_v[i], kbr_v[i], kbi_v[i], dv_v[i], rdd_v[i], madr_v[i], mdat_v[i]}
                !== {5'b00100, 48'h0}) begin
                n_err++; $display("FAIL midreset_state dut%0d: got rdy=%b wren=%b kbr=%b kbi=%b dv=%b rd=%h addr=%h data=%h",
                                  i, rdy_v[i], wren_v[i], kbr_v[i], kbi_v[i], dv_v[i], rdd_v[i], madr_v[i], mdat_v[i]);
            end
        end
        @(posedge clk); #1;
        reset = 1'b1;
        model_reset();
        pulses[0] = 0; pulses[1] = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            for (int i = 0; i < 2; i++) if (rdy_v[i]) pulses[i]++;
        end
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (pulses[i] !== 0) begin n_err++; $display("FAIL midreset_no_ready dut%0d: got %0d pulses want 0", i, pulses[i]); end
        end
        model_access(1'b1, 16'h2223, 16'h5A5A, exp);
        access(1'b1, 16'h2223, 16'h5A5A);
        model_access(1'b0, 16'h2223, 16'h0, exp);
        access(1'b0, 16'h2223, 16'h0);
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (res_q[i] !== exp || res_lat[i] !== exp_lat(i, 16'h2223)) begin
                n_err++; $display("FAIL midreset_next_access dut%0d: got %h at %0d want %h at %0d", i, res_q[i], res_lat[i], exp, exp_lat(i, 16'h2223));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp;
        int          npulse [2];
        model_access(1'b1, 16'hFE01, 16'h1234, exp);
        access(1'b1, 16'hFE01, 16'h1234);
        model_access(1'b0, 16'hFE01, 16'h0, exp);
        npulse[0] = 0; npulse[1] = 0;
        @(posedge clk); #1;
        mio_en0 = 1'b1; mio_en1 = 1'b1; r_w = 1'b0; mar = 16'hFE01;
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk); #1;
            // Third access is sampled at edge 2*(L+3); release afterwards.
            if (c == 2 * (lat_of(0) + 3) + 1) mio_en0 = 1'b0;
            if (c == 2 * (lat_of(1) + 3) + 1) mio_en1 = 1'b0;
            for (int i = 0; i < 2; i++) begin
                if (rdy_v[i]) begin
                    $display("back-to-back dut%0d: pulse %0d at cycle %0d rd_data=%h", i, npulse[i], c, rdd_v[i]);
                    n_cmp++;
                    if (c !== (npulse[i] + 1) * (lat_of(i) + 3) - 1 || rdd_v[i] !== exp) begin
                        n_err++; $display("FAIL b2b_pulse dut%0d: got cycle %0d data %h want cycle %0d data %h",
                                          i, c, rdd_v[i], (npulse[i] + 1) * (lat_of(i) + 3) - 1, exp);
                    end
                    npulse[i]++;
                end
            end
        end
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (npulse[i] !== 3) begin n_err++; $display("FAIL b2b_count dut%0d: got %0d pulses want 3", i, npulse[i]); end
        end
    endtask

    task automatic test_random();
        logic [15:0] exp, a, d;
        logic        w;
        logic [15:0] wq [$];
        int          r;
        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 9);
            d = 16'($urandom);
            if (r < 4 || wq.size() == 0) begin
                w = 1'b1; a = 16'($urandom);
                if (is_reg(a)) a = a ^ 16'h0100;
                wq.push_back(a);
            end else if (r < 7) begin
                w = 1'b0; a = wq[$urandom_range(0, wq.size() - 1)];
            end else begin
                w = (r == 9);
                case ($urandom_range(0, 3))
                    0: a = A_KBSR;
                    1: a = A_KBDR;
                    2: a = A_DSR;
                    default: a = A_DDR;
                endcase
            end
            model_access(w, a, d, exp);
            access(w, a, d);
            for (int i = 0; i < 2; i++) begin
                $display("random %0d dut%0d: %s addr=%h data=%h rd_data=%h cycle=%0d",
                         n, i, w ? "wr" : "rd", a, d, res_q[i], res_lat[i]);
                n_cmp++;
                if (res_q[i] !== exp || res_lat[i] !== exp_lat(i, a) || res_rdy[i] !== 1) begin
                    n_err++; $display("FAIL rand_access dut%0d: got %h at %0d width %0d want %h at %0d width 1",
                                      i, res_q[i], res_lat[i], res_rdy[i], exp, exp_lat(i, a));
                end
                n_cmp++;
                if (res_wren[i] !== ((w && !is_reg(a)) ? 1 : 0)) begin
                    n_err++; $display("FAIL rand_wren dut%0d: got %0d want %0d", i, res_wren[i], (w && !is_reg(a)) ? 1 : 0);
                end
                n_cmp++;
                if ({kbi_v[i], kbr_v[i], dv_v[i], dd_v[i]} !== {ref_full & ref_ie, ~ref_full, ~ref_drdy, ref_ddr}) begin
                    n_err++; $display("FAIL rand_flags dut%0d: got int=%b kbr=%b dv=%b dd=%h want %b %b %b %h",
                                      i, kbi_v[i], kbr_v[i], dv_v[i], dd_v[i], ref_full & ref_ie, ~ref_full, ~ref_drdy, ref_ddr);
                end
            end
            if (!ref_drdy && $urandom_range(0, 1) == 1) disp_pulse();
        end
    endtask

    initial begin
        test_reset();
        test_ram();
        test_keyboard();
        test_interrupt();
        test_display();
        test_reset_mid_access();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
